// File: rtl/hlu_pkg.sv
// Shared definitions for the HI/LO unit: op codes, default latencies and
// the width of the busy countdown.
package hlu_pkg;

    typedef logic [3:0] hlu_op_t;

    localparam hlu_op_t NONE  = 4'd0;
    localparam hlu_op_t MULT  = 4'd1;
    localparam hlu_op_t MULTU = 4'd2;
    localparam hlu_op_t DIV   = 4'd3;
    localparam hlu_op_t DIVU  = 4'd4;
    localparam hlu_op_t MTHI  = 4'd5;
    localparam hlu_op_t MTLO  = 4'd6;
    localparam hlu_op_t MFHI  = 4'd7;
    localparam hlu_op_t MFLO  = 4'd8;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/hlu_divider.sv
// Combinational 32-bit divider: magnitude divide followed by sign fix-up.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module hlu_divider (
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_divZero
);

    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_magQ;
    logic [31:0] w_magR;
    logic        w_overflow;

    assign w_negA = i_signed & i_dividend[31];
    assign w_negB = i_signed & i_divisor[31];
    assign w_magA = w_negA ? (32'd0 - i_dividend) : i_dividend;
    assign w_magB = w_negB ? (32'd0 - i_divisor) : i_divisor;

    assign o_divZero = (i_divisor == 32'd0);

    // Guard the zero divisor so the magnitude divide never sees it.
    assign w_magQ = o_divZero ? 32'd0 : (w_magA / w_magB);
    assign w_magR = o_divZero ? 32'd0 : (w_magA % w_magB);

    assign w_overflow = i_signed && (i_dividend == 32'h8000_0000) &&
                        (i_divisor == 32'hFFFF_FFFF);

    assign o_quotient  = w_overflow ? 32'h8000_0000 :
                         ((w_negA ^ w_negB) ? (32'd0 - w_magQ) : w_magQ);
    assign o_remainder = w_overflow ? 32'd0 :
                         (w_negA ? (32'd0 - w_magR) : w_magR);

endmodule

// File: rtl/hlu_unit.sv
// Execute-stage HI/LO unit: multiply/divide with a fixed busy period,
// mthi/mtlo writes and a combinational mfhi/mflo read path.
module hlu_unit
    import hlu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        start,
    input  hlu_op_t     op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hluResult
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_shHi;
    logic [31:0]      r_shLo;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_divZero;

    logic             w_accept;
    logic [63:0]      w_extA;
    logic [63:0]      w_extB;
    logic [63:0]      w_prodS;
    logic [63:0]      w_prodU;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic             w_divZero;

    assign w_accept = start & ~Req & ~r_busy;

    assign w_extA  = {{32{rs[31]}}, rs};
    assign w_extB  = {{32{rt[31]}}, rt};
    assign w_prodS = w_extA * w_extB;
    assign w_prodU = {32'd0, rs} * {32'd0, rt};

    hlu_divider u_divider (
        .i_signed    (op == DIV),
        .i_dividend  (rs),
        .i_divisor   (rt),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_divZero   (w_divZero)
    );

    // Results park in the shadow registers and commit when the countdown
    // expires, so HI/LO always hold the last completed result while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_shHi    <= 32'd0;
            r_shLo    <= 32'd0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_divZero <= 1'b0;
        end else if (r_busy) begin
            r_count <= r_count - 1'b1;
            if (r_count == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!r_divZero) begin
                    r_hi <= r_shHi;
                    r_lo <= r_shLo;
                end
            end
        end else if (w_accept) begin
            case (op)
                MULT: begin
                    {r_shHi, r_shLo} <= w_prodS;
                    r_count          <= MULT_CNT;
                    r_busy           <= 1'b1;
                    r_divZero        <= 1'b0;
                end
                MULTU: begin
                    {r_shHi, r_shLo} <= w_prodU;
                    r_count          <= MULT_CNT;
                    r_busy           <= 1'b1;
                    r_divZero        <= 1'b0;
                end
                DIV, DIVU: begin
                    r_shLo    <= w_quot;
                    r_shHi    <= w_rem;
                    r_count   <= DIV_CNT;
                    r_busy    <= 1'b1;
                    r_divZero <= w_divZero;
                end
                MTHI: r_hi <= rs;
                MTLO: r_lo <= rs;
                default: ;
            endcase
        end
    end

    always_comb begin
        hluResult = 32'd0;
        case (op)
            MFHI:    hluResult = r_hi;
            MFLO:    hluResult = r_lo;
            default: hluResult = 32'd0;
        endcase
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_hlu_unit.sv
// Self-checking bench for hlu_unit: directed scenarios plus randomized ops
// against an arithmetic model of the architectural HI/LO state.
module tb_hlu_unit;
    import hlu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hluResult;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mHi;
    logic [31:0] mLo;

    hlu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .Req       (Req),
        .start     (start),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .hluResult (hluResult)
    );

    always #5 clk = ~clk;

    function automatic int opCycles(logic [3:0] o);
        if (o == MULT || o == MULTU) return 5;
        if (o == DIV || o == DIVU) return 10;
        return 0;
    endfunction

    // Final architectural effect of an accepted op, from plain 64-bit arithmetic.
    task automatic modelAccept(logic [3:0] o, logic [31:0] a, logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MULT:  begin up = sa * sb; mHi = up[63:32]; mLo = up[31:0]; end
            MULTU: begin up = ua * ub; mHi = up[63:32]; mLo = up[31:0]; end
            DIV:   if (b != 0) begin sq = sa / sb; sr = sa % sb; mLo = sq[31:0]; mHi = sr[31:0]; end
            DIVU:  if (b != 0) begin up = ua / ub; mLo = up[31:0]; up = ua % ub; mHi = up[31:0]; end
            MTHI:  mHi = a;
            MTLO:  mLo = a;
            default: ;
        endcase
    endtask

    task automatic driveOp(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic rq);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b; Req = rq;
        @(negedge clk);
        start = 1'b0; op = NONE; rs = 32'd0; rt = 32'd0; Req = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_state: busy=%0b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        @(negedge clk); reset = 1'b1;
        driveOp(MTHI, 32'h1234, 32'd0, 1'b0);
        driveOp(MTLO, 32'h5678, 32'd0, 1'b0);
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++; $display("[TB] FAIL preload: hi=%h lo=%h expected 1234/5678", hi, lo);
        end
        driveOp(MULT, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_mid_mult: busy=%0b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        @(negedge clk); reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_after_release: busy=%0b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        mHi = 32'd0; mLo = 32'd0;
    endtask

    // Directed multiply/divide table with hand-derived expected HI/LO.
    task automatic test_muldiv();
        logic [3:0]  to [7] = '{MULT, MULTU, DIV, DIV, DIV, DIVU, MULT};
        logic [31:0] ta [7] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h80000000,
                                32'h00000007, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] tb [7] = '{32'd3, 32'd3, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2, 32'h80000000};
        logic [31:0] eh [7] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000001, 32'h00000001, 32'h40000000};
        logic [31:0] el [7] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'h80000000,
                                32'hFFFFFFFD, 32'h7FFFFFFC, 32'h00000000};
        int          n;
        for (int k = 0; k < 7; k++) begin
            driveOp(to[k], ta[k], tb[k], 1'b0);
            n = opCycles(to[k]);
            for (int i = 0; i < n; i++) begin
                checks++; if (busy !== 1'b1 || hi !== mHi || lo !== mLo) begin
                    errors++; $display("[TB] FAIL muldiv_busy[%0d] cyc %0d: busy=%0b hi=%h lo=%h expected 1/%h/%h",
                                       k, i, busy, hi, lo, mHi, mLo);
                end
                @(negedge clk);
            end
            checks++; if (busy !== 1'b0 || hi !== eh[k] || lo !== el[k]) begin
                errors++; $display("[TB] FAIL muldiv_result[%0d]: busy=%0b hi=%h lo=%h expected 0/%h/%h",
                                   k, busy, hi, lo, eh[k], el[k]);
            end
            mHi = eh[k]; mLo = el[k];
        end
    endtask

    task automatic test_divzero();
        driveOp(MTHI, 32'h11, 32'd0, 1'b0);
        driveOp(MTLO, 32'h22, 32'd0, 1'b0);
        driveOp(DIVU, 32'd7, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (busy !== 1'b1) begin
                errors++; $display("[TB] FAIL divzero_busy cyc %0d: busy=%0b expected 1", i, busy);
            end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            errors++; $display("[TB] FAIL divzero_result: busy=%0b hi=%h lo=%h expected 0/11/22", busy, hi, lo);
        end
        mHi = 32'h11; mLo = 32'h22;
    endtask

    task automatic test_req_block();
        driveOp(MULT, 32'd5, 32'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
                errors++; $display("[TB] FAIL req_mult cyc %0d: busy=%0b hi=%h lo=%h expected 0/11/22", i, busy, hi, lo);
            end
            @(negedge clk);
        end
        driveOp(MTLO, 32'h55, 32'd0, 1'b1);
        checks++; if (lo !== 32'h22) begin
            errors++; $display("[TB] FAIL req_mtlo: lo=%h expected 22", lo);
        end
    endtask

    task automatic test_back_to_back();
        driveOp(DIV, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (busy !== 1'b1 || hi !== 32'h11 || lo !== 32'h22) begin
                errors++; $display("[TB] FAIL inflight_busy cyc %0d: busy=%0b hi=%h lo=%h expected 1/11/22", i, busy, hi, lo);
            end
            start = 1'b0; Req = 1'b0; op = NONE;
            if (i == 3) begin start = 1'b1; Req = 1'b1; op = MTLO; rs = 32'hDEAD; end
            if (i == 5) begin start = 1'b1; op = MTHI; rs = 32'hBEEF; end
            @(negedge clk);
        end
        start = 1'b0; Req = 1'b0; op = NONE;
        checks++; if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("[TB] FAIL inflight_result: busy=%0b hi=%h lo=%h expected 0/2/e", busy, hi, lo);
        end
        start = 1'b1; op = MTLO; rs = 32'h77;
        @(negedge clk);
        start = 1'b0; op = NONE; rs = 32'd0;
        checks++; if (lo !== 32'h77 || hi !== 32'd2) begin
            errors++; $display("[TB] FAIL next_accept: hi=%h lo=%h expected 2/77", hi, lo);
        end
        mHi = 32'd2; mLo = 32'h77;
    endtask

    task automatic test_mfhilo();
        op = MFHI; #1;
        checks++; if (hluResult !== mHi) begin
            errors++; $display("[TB] FAIL mfhi: hluResult=%h expected %h", hluResult, mHi);
        end
        op = MFLO; #1;
        checks++; if (hluResult !== mLo) begin
            errors++; $display("[TB] FAIL mflo: hluResult=%h expected %h", hluResult, mLo);
        end
        op = MULT; #1;
        checks++; if (hluResult !== 32'd0) begin
            errors++; $display("[TB] FAIL result_other: hluResult=%h expected 0", hluResult);
        end
        op = NONE;
    endtask

    task automatic test_random();
        logic [3:0]  opList [9] = '{NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO};
        logic [3:0]  o;
        logic [31:0] a, b, oldHi, oldLo;
        logic        rq;
        int          n;
        for (int k = 0; k < 40; k++) begin
            o  = opList[$urandom_range(0, 8)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            rq = ($urandom_range(0, 5) == 0);
            oldHi = mHi; oldLo = mLo;
            driveOp(o, a, b, rq);
            n = rq ? 0 : opCycles(o);
            if (!rq) modelAccept(o, a, b);
            for (int i = 0; i < n; i++) begin
                checks++; if (busy !== 1'b1 || hi !== oldHi || lo !== oldLo) begin
                    errors++; $display("[TB] FAIL rand_busy[%0d] op %0d cyc %0d: busy=%0b hi=%h lo=%h expected 1/%h/%h",
                                       k, o, i, busy, hi, lo, oldHi, oldLo);
                end
                @(negedge clk);
            end
            checks++; if (busy !== 1'b0 || hi !== mHi || lo !== mLo) begin
                errors++; $display("[TB] FAIL rand_result[%0d] op %0d a=%h b=%h req=%0b: busy=%0b hi=%h lo=%h expected 0/%h/%h",
                                   k, o, a, b, rq, busy, hi, lo, mHi, mLo);
            end
        end
    endtask

    initial begin
        reset = 1'b0; Req = 1'b0; start = 1'b0; op = NONE; rs = 32'd0; rt = 32'd0;
        mHi = 32'd0; mLo = 32'd0;
        test_reset();
        test_muldiv();
        test_divzero();
        test_req_block();
        test_back_to_back();
        test_mfhilo();
        test_random();
        test_mfhilo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
